// File: rtl/req_gnt_chk_pkg.sv
// Shared state encodings, error codes and the error-name helper for the req/gnt checker.
// err_code_name is only called when REQ_GNT_CHK_DISPLAY_EN is defined.
package req_gnt_chk_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT = 2'd1;
  localparam logic [1:0] ST_CHK_DROP = 2'd2;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_REQ_IN_WAIT  = 3'd1,
    ERR_EARLY_GNT    = 3'd2,
    ERR_TIMEOUT      = 3'd3,
    ERR_GNT_HELD     = 3'd4,
    ERR_REQ_IN_DROP  = 3'd5,
    ERR_SPURIOUS_GNT = 3'd6
  } err_code_t;

  function automatic string err_code_name(input logic [2:0] code);
    case (code)
      3'd0:    return "NONE";
      3'd1:    return "REQ_IN_WAIT";
      3'd2:    return "EARLY_GNT";
      3'd3:    return "TIMEOUT";
      3'd4:    return "GNT_HELD";
      3'd5:    return "REQ_IN_DROP";
      3'd6:    return "SPURIOUS_GNT";
      default: return "UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/req_gnt_chk_chan.sv
// One req/gnt channel checker: FSM, latency counter, registered pass/fail pulses,
// last error code and saturating pass/fail counters.
module req_gnt_chk_chan
  import req_gnt_chk_pkg::*;
#(
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  input  logic             chk_en_ip,
  input  logic             req_ip,
  input  logic             gnt_ip,
  output logic             pass_op,
  output logic             fail_op,
  output logic [2:0]       err_code_op,
  output logic [CNT_W-1:0] pass_cnt_op,
  output logic [CNT_W-1:0] fail_cnt_op
);

  localparam int               LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MIN = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             dec_pass, dec_fail;
  err_code_t        dec_code, err_q;
  logic             pass_q, fail_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

  // lat counts edges since req was accepted, so lat equals L on the edge gnt is sampled
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    dec_pass = 1'b0;
    dec_fail = 1'b0;
    dec_code = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (gnt_ip) begin
          dec_fail = 1'b1;
          dec_code = ERR_SPURIOUS_GNT;
        end else if (req_ip) begin
          state_d = ST_WAIT_GNT;
          lat_d   = LAT_W'(1);
        end
      end
      ST_WAIT_GNT: begin
        if (req_ip) begin
          dec_fail = 1'b1;
          dec_code = ERR_REQ_IN_WAIT;
        end else if (gnt_ip && (lat_q < LAT_MIN)) begin
          dec_fail = 1'b1;
          dec_code = ERR_EARLY_GNT;
        end else if (gnt_ip) begin
          state_d = ST_CHK_DROP;
        end else if (lat_q == LAT_MAX) begin
          dec_fail = 1'b1;
          dec_code = ERR_TIMEOUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
        if (dec_fail) state_d = ST_IDLE;
      end
      ST_CHK_DROP: begin
        state_d = ST_IDLE;
        if (gnt_ip) begin
          dec_fail = 1'b1;
          dec_code = ERR_GNT_HELD;
        end else if (req_ip) begin
          dec_fail = 1'b1;
          dec_code = ERR_REQ_IN_DROP;
        end else begin
          dec_pass = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Disable drops any in-flight check without a pulse; counters and error code hold
  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= ERR_NONE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else if (!chk_en_ip) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      pass_q  <= dec_pass;
      fail_q  <= dec_fail;
      if (dec_fail) err_q <= dec_code;
      if (dec_pass && (pass_cnt_q != CNT_MAX)) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      if (dec_fail && (fail_cnt_q != CNT_MAX)) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
    end
  end

  assign pass_op     = pass_q;
  assign fail_op     = fail_q;
  assign err_code_op = err_q;
  assign pass_cnt_op = pass_cnt_q;
  assign fail_cnt_op = fail_cnt_q;

endmodule

// File: rtl/req_gnt_chk_multi.sv
// NUM_CH-channel req/gnt protocol checker: channel instances, bus packing and sticky any_fail.
// Define REQ_GNT_CHK_DISPLAY_EN to print every pass/fail pulse in simulation.
module req_gnt_chk_multi
  import req_gnt_chk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_ip,
  input  logic                    reset_ip,
  input  logic                    chk_en_ip,
  input  logic [NUM_CH-1:0]       req_ip,
  input  logic [NUM_CH-1:0]       gnt_ip,
  output logic [NUM_CH-1:0]       pass_op,
  output logic [NUM_CH-1:0]       fail_op,
  output logic [3*NUM_CH-1:0]     err_code_op,
  output logic [CNT_W*NUM_CH-1:0] pass_cnt_op,
  output logic [CNT_W*NUM_CH-1:0] fail_cnt_op,
  output logic                    any_fail_op
);

  logic any_fail_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    req_gnt_chk_chan #(
      .MIN_LAT (MIN_LAT),
      .MAX_LAT (MAX_LAT),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk_ip      (clk_ip),
      .reset_ip    (reset_ip),
      .chk_en_ip   (chk_en_ip),
      .req_ip      (req_ip[i]),
      .gnt_ip      (gnt_ip[i]),
      .pass_op     (pass_op[i]),
      .fail_op     (fail_op[i]),
      .err_code_op (err_code_op[3*i +: 3]),
      .pass_cnt_op (pass_cnt_op[CNT_W*i +: CNT_W]),
      .fail_cnt_op (fail_cnt_op[CNT_W*i +: CNT_W])
    );
  end

  // The live fail pulse is ORed in so any_fail rises in the same cycle as the first fail
  always_ff @(posedge clk_ip) begin
    if (reset_ip) any_fail_q <= 1'b0;
    else          any_fail_q <= any_fail_q | (|fail_op);
  end

  assign any_fail_op = any_fail_q | (|fail_op);

`ifdef REQ_GNT_CHK_DISPLAY_EN
  always @(posedge clk_ip) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (pass_op[i])
        $display("%0t req_gnt_chk ch%0d PASS %s", $time, i, err_code_name(ERR_NONE));
      if (fail_op[i])
        $display("%0t req_gnt_chk ch%0d FAIL %s", $time, i, err_code_name(err_code_op[3*i +: 3]));
    end
  end
`else
`endif

endmodule

// File: tb/tb_req_gnt_chk_multi.sv
// Self-checking bench for req_gnt_chk_multi (MIN_LAT=2, MAX_LAT=4, CNT_W=2):
// directed protocol scenarios followed by random traffic against a cycle-stamp reference model.
module tb_req_gnt_chk_multi;

  localparam int NUM_CH  = 4;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk_ip = 1'b0;
  logic                    reset_ip;
  logic                    chk_en_ip;
  logic [NUM_CH-1:0]       req_ip;
  logic [NUM_CH-1:0]       gnt_ip;
  logic [NUM_CH-1:0]       pass_op;
  logic [NUM_CH-1:0]       fail_op;
  logic [3*NUM_CH-1:0]     err_code_op;
  logic [CNT_W*NUM_CH-1:0] pass_cnt_op;
  logic [CNT_W*NUM_CH-1:0] fail_cnt_op;
  logic                    any_fail_op;

  always #5 clk_ip = ~clk_ip;

  req_gnt_chk_multi #(
    .NUM_CH  (NUM_CH),
    .MIN_LAT (MIN_LAT),
    .MAX_LAT (MAX_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_ip      (clk_ip),
    .reset_ip    (reset_ip),
    .chk_en_ip   (chk_en_ip),
    .req_ip      (req_ip),
    .gnt_ip      (gnt_ip),
    .pass_op     (pass_op),
    .fail_op     (fail_op),
    .err_code_op (err_code_op),
    .pass_cnt_op (pass_cnt_op),
    .fail_cnt_op (fail_cnt_op),
    .any_fail_op (any_fail_op)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: each channel remembers the cycle its req was accepted and the cycle gnt arrived
  int                start_c [NUM_CH];
  int                grant_c [NUM_CH];
  int                exp_err [NUM_CH];
  int                exp_pcnt[NUM_CH];
  int                exp_fcnt[NUM_CH];
  logic [NUM_CH-1:0] exp_pass;
  logic [NUM_CH-1:0] exp_fail;
  logic              exp_any;

  task automatic modelStep(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] gnt,
                           input logic en, input logic rst);
    cyc++;
    exp_pass = '0;
    exp_fail = '0;
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        start_c[ch] = -1; grant_c[ch] = -1;
        exp_err[ch] = 0; exp_pcnt[ch] = 0; exp_fcnt[ch] = 0;
      end
      exp_any = 1'b0;
      return;
    end
    if (!en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        start_c[ch] = -1; grant_c[ch] = -1;
      end
      return;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int code;
      int lat;
      bit passed;
      code   = -1;
      passed = 1'b0;
      if (start_c[ch] < 0) begin
        if (gnt[ch])      code = 6;
        else if (req[ch]) start_c[ch] = cyc;
      end else if (grant_c[ch] < 0) begin
        lat = cyc - start_c[ch];
        if (req[ch])                      code = 1;
        else if (gnt[ch] && lat < MIN_LAT) code = 2;
        else if (gnt[ch])                 grant_c[ch] = cyc;
        else if (lat >= MAX_LAT)          code = 3;
      end else begin
        if (gnt[ch])      code = 4;
        else if (req[ch]) code = 5;
        else              passed = 1'b1;
      end
      if (code >= 0) begin
        exp_fail[ch] = 1'b1;
        exp_err[ch]  = code;
        if (exp_fcnt[ch] < CNT_MAX) exp_fcnt[ch]++;
        start_c[ch] = -1; grant_c[ch] = -1;
      end
      if (passed) begin
        exp_pass[ch] = 1'b1;
        if (exp_pcnt[ch] < CNT_MAX) exp_pcnt[ch]++;
        start_c[ch] = -1; grant_c[ch] = -1;
      end
    end
    exp_any = exp_any | (|exp_fail);
  endtask

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic checkOutput();
    logic [3*NUM_CH-1:0]     e_err;
    logic [CNT_W*NUM_CH-1:0] e_pc;
    logic [CNT_W*NUM_CH-1:0] e_fc;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_err[3*ch +: 3]       = 3'(exp_err[ch]);
      e_pc[CNT_W*ch +: CNT_W] = CNT_W'(exp_pcnt[ch]);
      e_fc[CNT_W*ch +: CNT_W] = CNT_W'(exp_fcnt[ch]);
    end
    checkVal("pass_op",     64'(pass_op),     64'(exp_pass));
    checkVal("fail_op",     64'(fail_op),     64'(exp_fail));
    checkVal("err_code_op", 64'(err_code_op), 64'(e_err));
    checkVal("pass_cnt_op", 64'(pass_cnt_op), 64'(e_pc));
    checkVal("fail_cnt_op", 64'(fail_cnt_op), 64'(e_fc));
    checkVal("any_fail_op", 64'(any_fail_op), 64'(exp_any));
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] gnt,
                               input logic en, input logic rst);
    req_ip    = req;
    gnt_ip    = gnt;
    chk_en_ip = en;
    reset_ip  = rst;
    @(posedge clk_ip);
    modelStep(req, gnt, en, rst);
    #1;
    checkOutput();
  endtask

  initial begin
    reset_ip  = 1'b1;
    chk_en_ip = 1'b1;
    req_ip    = '0;
    gnt_ip    = '0;
    exp_any   = 1'b0;

    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1);
    checkVal("reset_pass_cnt", 64'(pass_cnt_op), 64'd0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);

    // ch0 legal transaction with latency 3
    applyStimulus(4'h1, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h1, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    checkVal("ch0_first_pass", 64'(pass_op[0]), 64'd1);
    checkVal("ch0_pass_cnt", 64'(pass_cnt_op[CNT_W-1:0]), 64'd1);

    // ch1 grant one cycle after req: early
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h2, 1'b1, 1'b0);
    checkVal("ch1_early_code", 64'(err_code_op[5:3]), 64'd2);
    checkVal("any_fail_first", 64'(any_fail_op), 64'd1);

    // ch1 at MIN_LAT and at MAX_LAT both pass
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);

    // ch1 timeout: no grant within MAX_LAT
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    checkVal("ch1_timeout_code", 64'(err_code_op[5:3]), 64'd3);

    // ch2 req held, ch2 gnt held, ch3 spurious grant
    applyStimulus(4'h4, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h4, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h4, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h4, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h4, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h8, 1'b1, 1'b0);
    checkVal("ch3_spurious_code", 64'(err_code_op[11:9]), 64'd6);

    // All channels finish together with mixed outcomes
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'hF, 1'b1, 1'b0);
    applyStimulus(4'h4, 4'h2, 1'b1, 1'b0);

    // ch0 pass counter saturates
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'h1, 4'h0, 1'b1, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
      applyStimulus(4'h0, 4'h1, 1'b1, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    end
    checkVal("ch0_pass_sat", 64'(pass_cnt_op[CNT_W-1:0]), 64'(CNT_MAX));

    // Reset while ch0 waits, then disable while ch1 is checking the drop
    applyStimulus(4'h1, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1);
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h2, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h2, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);

    // Random traffic with occasional disable and reset
    for (int k = 0; k < 600; k++) begin
      logic [NUM_CH-1:0] r;
      logic [NUM_CH-1:0] g;
      r = NUM_CH'($urandom & $urandom);
      g = NUM_CH'($urandom & $urandom);
      applyStimulus(r, g, ($urandom_range(0, 19) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/req_gnt_chk_multi.md
Name: req_gnt_chk_multi

Overview:
- Synthesisable, parametrised request/grant protocol checker for NUM_CH independent channels.
- Per channel it checks that a single-cycle req is followed by a single-cycle gnt within [MIN_LAT, MAX_LAT] cycles, with req low throughout, then both low one cycle later.
- It reports pass/fail pulses, a per-channel error code, and saturating pass/fail counters.
- It is bound beside a DUT and generalises the fixed-latency single-channel req/gnt check.

Parameters:
- NUM_CH, 4: number of independent req/gnt channels (≥1).
- MIN_LAT, 1: minimum legal req-to-gnt latency in cycles (≥1).
- MAX_LAT, 1: maximum legal latency in cycles (≥MIN_LAT). MIN_LAT=MAX_LAT=1 gives the legacy single-latency check.
- CNT_W, 16: width of each pass/fail counter.

Ports:
- clk_ip  input  1  sampling clock; all logic on posedge.
- reset_ip  input  1  synchronous, active-high reset.
- chk_en_ip  input  1  checking enable; low holds all channels in IDLE and suppresses pulses; counters hold.
- req_ip  input  NUM_CH  request per channel.
- gnt_ip  input  NUM_CH  grant per channel.
- pass_op  output  NUM_CH  one-cycle pass pulse per channel.
- fail_op  output  NUM_CH  one-cycle fail pulse per channel.
- err_code_op  output  3*NUM_CH  last error code per channel; channel i occupies bits [3i+2:3i].
- pass_cnt_op  output  CNT_W*NUM_CH  saturating pass count per channel.
- fail_cnt_op  output  CNT_W*NUM_CH  saturating fail count per channel.
- any_fail_op  output  1  sticky OR of all failures since reset.

Behaviour:
- Reset (synchronous, active-high): all FSMs go to IDLE; every output is 0 and every counter is 0. Reset mid-transaction abandons it silently with no pulse.
- Error codes: 0 NONE, 1 REQ_IN_WAIT, 2 EARLY_GNT, 3 TIMEOUT, 4 GNT_HELD, 5 REQ_IN_DROP, 6 SPURIOUS_GNT.
- Per-channel FSM states: IDLE, WAIT_GNT, CHK_DROP. Latency counter lat width is clog2(MAX_LAT+1).
- IDLE:
  - gnt=1 → fail SPURIOUS_GNT; stay IDLE. A req in the same cycle is ignored.
  - Otherwise req=1 → WAIT_GNT with lat=1.
- WAIT_GNT, evaluated in priority order:
  - req=1 → fail REQ_IN_WAIT.
  - gnt=1 and lat<MIN_LAT → fail EARLY_GNT.
  - gnt=1 → CHK_DROP.
  - lat==MAX_LAT → fail TIMEOUT.
  - Otherwise lat increments.
  - Every fail returns the FSM to IDLE.
- CHK_DROP: gnt=1 → fail GNT_HELD; else req=1 → fail REQ_IN_DROP; else pass. All three outcomes → IDLE.
- Latency: a req sampled at edge t with gnt at edge t+L is legal for MIN_LAT≤L≤MAX_LAT; the pass decision is at t+L+1.
- Outputs are registered: pass_op/fail_op pulse for exactly one cycle, one cycle after the deciding edge.
- err_code_op updates on the same cycle as fail_op and holds until the next fail or reset. A pass leaves it unchanged.
- Counters:
  - Increment on the same cycle as the pulse.
  - Saturate at 2^CNT_W−1 (no wrap).
  - Channels that pulse in the same cycle update independently.
- any_fail_op sets on the first fail_op bit and clears only on reset.
- chk_en_ip low forces IDLE on the next edge. An in-flight transaction is dropped with no pulse. Re-enabling starts fresh.
- Pipelined back-to-back use is not supported: a new req is only accepted from IDLE, so a req in the cycle after a pass starts a new check.

Optional Feature:
- Macro: REQ_GNT_CHK_DISPLAY_EN.
- Defined: on every pass/fail pulse, a non-synthesisable $display prints time, channel, PASS/FAIL and the error-code name.
- Undefined: no display code is compiled; RTL behaviour is otherwise identical.

Decomposition:
- Package req_gnt_chk_pkg holds:
  - the state enum (IDLE, WAIT_GNT, CHK_DROP);
  - the 3-bit err_code_t enum and its constants;
  - a function returning the error-code name string for display.
- Sub-module req_gnt_chk_chan contains one channel: FSM, latency counter, pass/fail registers and counters. It is instantiated NUM_CH times in a generate loop.
- The top level only adds the any_fail_op sticky OR and bus packing.

Test Plan:
- Defaults, MIN_LAT=MAX_LAT=1: ch0 req at edge 10, gnt at 11, both low at 12 → pass_op[0] at 13, pass_cnt ch0=1, err_code ch0=0.
- MIN_LAT=2, MAX_LAT=4: ch1 gnt 1 cycle after req → fail_op[1], err 2. Gnt 3 cycles after req → pass. No gnt for 4 cycles → err 3 at edge t+4.
- Ch2 req held 2 cycles → err 1. Ch2 gnt held 2 cycles → err 4. Ch3 gnt with no prior req → err 6. any_fail_op=1 after the first of these.
- All 4 channels complete simultaneously with mixed outcomes → the matching pass_op/fail_op bits in the same cycle; counters update independently.
- CNT_W=2: 5 passes on ch0 → pass_cnt ch0 saturates at 3.
- Assert reset_ip while ch0 is in WAIT_GNT, and drop chk_en_ip while ch1 is in CHK_DROP → no pulses; all outputs 0 after reset. The next req is checked normally.
